transceiver_ctrl: RTL and testbench
===================================

Name: transceiver_ctrl

Overview:
- Sequences the transceiver datapath: captures each byte the receiver completes, together with the decoder's error verdict, into a small FIFO.
- Drives the BPSK modulator's enable and input byte so each accepted byte is transmitted for a fixed number of cycles per bit.
- Discards errored bytes and keeps a count of them.
- Sits between receiver/decoder outputs and the modulator inputs at the transceiver top level.

Parameters:
- DATA_WIDTH, 8, byte width shared with receiver, decoder and modulator.
- SYM_CYCLES, 16, clock cycles the modulator stays enabled per data bit.
- FIFO_DEPTH, 4, entries in the byte queue (power of two, >=2).
- GAP_CYCLES, 4, idle cycles with modulator disabled between bytes.

Ports:
- clk  in  1  single system clock.
- arst  in  1  asynchronous reset, active-low.
- rx_done  in  1  one-cycle pulse: receiver has a complete byte.
- rx_byte  in  DATA_WIDTH  received byte, valid when rx_done=1.
- dec_err  in  1  decoder error flag for the byte qualified by rx_done.
- mod_en  out  1  modulator enable.
- mod_byte  out  DATA_WIDTH  byte presented to the modulator; held stable while mod_en=1.
- busy  out  1  high in any state except IDLE.
- fifo_full  out  1  queue holds FIFO_DEPTH entries.
- drop_cnt  out  8  saturating count of discarded bytes.

Behaviour:
- Reset (arst=0, asynchronous) state:
  - State IDLE; FIFO empty.
  - mod_en=0, mod_byte=0, busy=0, fifo_full=0, drop_cnt=0.
  - Bit counter and cycle counter cleared.
- Capture: on a clk edge with rx_done=1:
  - dec_err=0 and FIFO not full: push rx_byte.
  - dec_err=1: byte dropped, drop_cnt+1.
  - FIFO full: byte dropped, drop_cnt+1.
  - drop_cnt saturates at 255.
- FSM states: IDLE, LOAD, SEND, GAP.
- IDLE -> LOAD when FIFO non-empty.
- LOAD (1 cycle):
  - Pop head into mod_byte register.
  - Clear counters.
  - mod_en stays 0.
- SEND:
  - mod_en=1.
  - Cycle counter counts 0..SYM_CYCLES-1; on wrap, bit counter increments.
  - After DATA_WIDTH*SYM_CYCLES cycles -> GAP; mod_en falls on the first GAP cycle.
- GAP:
  - mod_en=0 for GAP_CYCLES cycles.
  - Then LOAD if FIFO non-empty, else IDLE.
  - mod_byte keeps its last value.
- Latency:
  - rx_done with empty FIFO and IDLE -> push at edge N.
  - LOAD at N+1; mod_en=1 from N+2.
- Simultaneous push and pop on a full FIFO: pop takes effect first, so the push is accepted (fifo_full is not used to drop it).
- Reset asserted mid-SEND: mod_en falls immediately (asynchronous) and queued bytes are lost.
- fifo_full and busy are registered and reflect state after the current edge.

Optional Feature:
- Macro: TRANSCEIVER_CTRL_PREAMBLE_EN.
- Defined:
  - A PREAMBLE state is inserted between LOAD and SEND. It transmits the constant PREAMBLE_BYTE (0xAA) for DATA_WIDTH*SYM_CYCLES cycles with mod_en=1.
  - While in PREAMBLE, mod_byte=0xAA; the data byte is then loaded into mod_byte on entry to SEND.
  - This applies only to the first byte after IDLE; back-to-back bytes skip the preamble.
- Undefined: no PREAMBLE state; behaviour exactly as above.

Decomposition:
- Shared package/header holds:
  - State encodings (IDLE=0, LOAD=1, SEND=2, GAP=3, PREAMBLE=4).
  - PREAMBLE_BYTE constant.
  - drop_cnt width constant (8).
- One sub-module: ctrl_byte_fifo, a synchronous FIFO with the same clk/arst.
  - Ports: push, pop, din, dout, full, empty.
  - Pointer wrap uses an extra MSB.
- FSM and counters live in transceiver_ctrl.

Test Plan:
1. Reset: arst=0 mid-run -> mod_en=0, drop_cnt=0, busy=0 at once; after release, IDLE.
2. Single byte: rx_done with rx_byte=0x5C, dec_err=0.
   - Required: mod_en=1 two cycles later for exactly 128 cycles (default params).
   - mod_byte=0x5C throughout.
   - Then 4 cycles mod_en=0, then busy=0.
3. Error drop: rx_done with rx_byte=0x11, dec_err=1 -> no transmission, drop_cnt=1, FIFO stays empty.
4. Overflow: 6 rx_done pulses of 0x01..0x06 while the FSM is held in SEND on a prior byte.
   - Required: fifo_full=1 after 4 pushes; drop_cnt=2.
   - Transmitted order 0x01..0x04.
5. Full and pop same cycle: FIFO full, push 0x77 on the LOAD cycle -> accepted; drop_cnt unchanged; 0x77 is transmitted last.
6. Preamble (macro defined): byte 0x3C from IDLE.
   - Required: 128 cycles with mod_byte=0xAA, then 128 cycles with 0x3C.
   - A second queued byte follows GAP with no preamble.

Source files
------------

// File: rtl/transceiver_ctrl_pkg.sv
// Shared definitions for the transceiver sequencing controller: state encodings
// and constants used by transceiver_ctrl and its byte FIFO.
package transceiver_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SEND     = 3'd2,
    ST_GAP      = 3'd3,
    ST_PREAMBLE = 3'd4
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam int         DROP_CNT_W    = 8;

endpackage

// File: rtl/ctrl_byte_fifo.sv
// Small synchronous byte queue; pointers carry an extra MSB to tell full from empty.
// A pop in the same cycle frees a slot, so a push on a full queue is accepted then.
module ctrl_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/transceiver_ctrl.sv
// Queues good received bytes and drives the BPSK modulator one byte at a time.
// Define TRANSCEIVER_CTRL_PREAMBLE_EN to send a 0xAA preamble before the first byte after idle.
//
// state    | meaning
// IDLE     | queue empty, modulator off
// LOAD     | pop queue head into mod_byte, clear counters
// PREAMBLE | modulator on with 0xAA (optional, first byte after idle only)
// SEND     | modulator on, SYM_CYCLES cycles per bit for DATA_WIDTH bits
// GAP      | modulator off for GAP_CYCLES cycles
module transceiver_ctrl
  import transceiver_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SYM_CYCLES = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_byte,
  input  logic                  dec_err,
  output logic                  mod_en,
  output logic [DATA_WIDTH-1:0] mod_byte,
  output logic                  busy,
  output logic                  fifo_full,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int CNT_MAX = (SYM_CYCLES > GAP_CYCLES) ? SYM_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] SYM_LAST = CW'(SYM_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   mod_byte_q, mod_byte_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic                    fifo_push, fifo_pop, fifo_empty, drop;
  logic [DATA_WIDTH-1:0]   fifo_dout;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    from_idle_q, from_idle_d;
`endif

  ctrl_byte_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .arst  (arst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rx_byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full queue only rejects when the controller is not popping this same cycle.
  assign fifo_push = rx_done && !dec_err;
  assign drop      = rx_done && (dec_err || (fifo_full && !fifo_pop));
  assign drop_d    = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      mod_byte_q  <= '0;
      drop_q      <= '0;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
      hold_q      <= '0;
      from_idle_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      mod_byte_q  <= mod_byte_d;
      drop_q      <= drop_d;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
      hold_q      <= hold_d;
      from_idle_q <= from_idle_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    mod_byte_d  = mod_byte_q;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
    hold_d      = hold_q;
    from_idle_d = from_idle_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
        from_idle_d = 1'b1;
`endif
      end
      ST_LOAD: begin
        cyc_d = '0;
        bit_d = '0;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
        if (from_idle_q) begin
          hold_d     = fifo_dout;
          mod_byte_d = DATA_WIDTH'(PREAMBLE_BYTE);
          state_d    = ST_PREAMBLE;
        end else begin
          mod_byte_d = fifo_dout;
          state_d    = ST_SEND;
        end
`else
        mod_byte_d = fifo_dout;
        state_d    = ST_SEND;
`endif
      end
      ST_PREAMBLE, ST_SEND: begin
        if (cyc_q == SYM_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (state_q == ST_PREAMBLE) begin
              state_d = ST_SEND;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
              mod_byte_d = hold_q;
`endif
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cyc_q == GAP_LAST) begin
          cyc_d   = '0;
          state_d = fifo_empty ? ST_IDLE : ST_LOAD;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
          from_idle_d = 1'b0;
`endif
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mod_en   = (state_q == ST_SEND) || (state_q == ST_PREAMBLE);
    busy     = (state_q != ST_IDLE);
    fifo_pop = (state_q == ST_LOAD);
  end

  assign mod_byte = mod_byte_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_transceiver_ctrl.sv
// Scoreboard bench for transceiver_ctrl: an event-timing reference model predicts
// accepted/dropped bytes and transmissions; a monitor checks outputs every cycle.
module tb_transceiver_ctrl;
  localparam int DW     = 8;
  localparam int SYM    = 16;
  localparam int DEPTH  = 4;
  localparam int GAP    = 4;
  localparam int TX_LEN = DW * SYM;
`ifdef TRANSCEIVER_CTRL_PREAMBLE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif
  localparam int L1 = PRE_EN ? 2 * TX_LEN : TX_LEN;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       rx_done = 1'b0;
  logic       dec_err = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       mod_en, busy, fifo_full;
  logic [7:0] mod_byte, drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  transceiver_ctrl #(
    .DATA_WIDTH (DW),
    .SYM_CYCLES (SYM),
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .rx_done   (rx_done),
    .rx_byte   (rx_byte),
    .dec_err   (dec_err),
    .mod_en    (mod_en),
    .mod_byte  (mod_byte),
    .busy      (busy),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt)
  );

  // Reference model state: queued bytes, expected transmissions {preamble, byte}.
  logic [7:0] mq[$];
  logic [8:0] exp_q[$];
  int  e_n, check_edge, pend_pop, tx_end, m_drop;
  bit  pend_valid, pend_pre;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task model_reset();
    mq.delete();
    exp_q.delete();
    e_n = 0; check_edge = 0; pend_pop = 0; tx_end = 0; m_drop = 0;
    pend_valid = 0; pend_pre = 0;
  endtask

  initial begin : model
    int occ0;
    bit pop_now;
    int len;
    logic [7:0] head;
    model_reset();
    forever begin
      @(posedge clk or negedge arst);
      if (!arst) begin
        model_reset();
      end else begin
        e_n++;
        occ0 = mq.size();
        pop_now = pend_valid && (pend_pop == e_n);
        if (rx_done) begin
          if (!dec_err && (occ0 < DEPTH || pop_now)) mq.push_back(rx_byte);
          else if (m_drop < 255) m_drop++;
        end
        if (pop_now) begin
          len = pend_pre ? 2 * TX_LEN : TX_LEN;
          head = mq.pop_front();
          exp_q.push_back({pend_pre, head});
          pend_valid = 0;
          tx_end = e_n + len;
          check_edge = e_n + len + GAP;
        end else if (!pend_valid && e_n >= check_edge && occ0 > 0) begin
          pend_valid = 1;
          pend_pop = e_n + 1;
          pend_pre = PRE_EN && (e_n > check_edge);
        end
      end
    end
  end

  initial begin : monitor
    logic [7:0] seg[$];
    logic [8:0] ent;
    int nbad;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (!arst) begin
        seg.delete();
      end else begin
        check("mod_en", int'(mod_en), int'(e_n < tx_end));
        check("busy", int'(busy), int'(pend_valid || e_n < check_edge));
        check("fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
        check("drop_cnt", int'(drop_cnt), m_drop);
        if (mod_en) begin
          seg.push_back(mod_byte);
        end else if (seg.size() > 0) begin
          if (exp_q.size() == 0) begin
            check("tx_unexpected_len", seg.size(), 0);
          end else begin
            ent = exp_q.pop_front();
            check("tx_len", seg.size(), ent[8] ? 2 * TX_LEN : TX_LEN);
            nbad = 0;
            foreach (seg[i]) begin
              want = (ent[8] && i < TX_LEN) ? 8'hAA : ent[7:0];
              if (seg[i] != want) nbad++;
            end
            check("tx_bad_bytes", nbad, 0);
            check("tx_last_byte", int'(seg[seg.size()-1]), int'(ent[7:0]));
          end
          seg.delete();
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] b, input logic err);
    @(negedge clk);
    rx_done = 1'b1; rx_byte = b; dec_err = err;
    @(negedge clk);
    rx_done = 1'b0; dec_err = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(e_n >= check_edge && !pend_valid && mq.size() == 0 && exp_q.size() == 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", int'(n < budget), 1);
  endtask

  initial begin : driver
    int n;
    arst = 1'b0;
    tick(3);
    arst = 1'b1;
    @(negedge clk);
    check("rst_mod_byte", int'(mod_byte), 0);
    check("rst_busy", int'(busy), 0);

    // single byte: latency, duration, gap
    pulse(8'h5C, 1'b0);
    @(negedge clk);
    check("lat1_mod_en", int'(mod_en), 0);
    check("lat1_busy", int'(busy), 1);
    @(negedge clk);
    check("lat2_mod_en", int'(mod_en), 1);
    check("lat2_mod_byte", int'(mod_byte), PRE_EN ? 8'hAA : 8'h5C);
    tick(L1 - 1);
    check("last_mod_en", int'(mod_en), 1);
    check("last_mod_byte", int'(mod_byte), 8'h5C);
    @(negedge clk);
    check("gap_mod_en", int'(mod_en), 0);
    check("gap_mod_byte", int'(mod_byte), 8'h5C);
    tick(3);
    check("gap_end_busy", int'(busy), 1);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // errored byte is dropped
    pulse(8'h11, 1'b1);
    tick(5);
    check("err_drop_cnt", int'(drop_cnt), 1);
    check("err_no_tx", int'(busy), 0);

    // overflow while a prior byte is on air
    pulse(8'hA0, 1'b0);
    tick(10);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) check("full_after_4", int'(fifo_full), 1);
      rx_done = 1'b1; rx_byte = 8'(i); dec_err = 1'b0;
    end
    @(negedge clk);
    rx_done = 1'b0;
    check("ovf_drop_cnt", int'(drop_cnt), 3);

    // push on the LOAD cycle of a full queue is accepted
    n = 0;
    while (!pend_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("load_seen", int'(n < 1000), 1);
    check("load_full", int'(fifo_full), 1);
    rx_done = 1'b1; rx_byte = 8'h77;
    @(negedge clk);
    rx_done = 1'b0;
    check("pop_push_drop_cnt", int'(drop_cnt), 3);
    check("pop_push_full", int'(fifo_full), 1);
    wait_idle(3000);

    // two close bytes from idle: only the first may carry a preamble
    pulse(8'h3C, 1'b0);
    pulse(8'h3D, 1'b0);
    wait_idle(1500);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rx_done = ($urandom_range(0, 99) < 3);
      rx_byte = 8'($urandom);
      dec_err = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    rx_done = 1'b0; dec_err = 1'b0;
    wait_idle(4000);

    // reset in the middle of a transmission with a byte queued
    pulse(8'hC3, 1'b0);
    tick(20);
    pulse(8'h44, 1'b0);
    check("pre_rst_mod_en", int'(mod_en), 1);
    #2 arst = 1'b0;
    #1;
    check("async_rst_mod_en", int'(mod_en), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_drop", int'(drop_cnt), 0);
    check("async_rst_full", int'(fifo_full), 0);
    check("async_rst_mod_byte", int'(mod_byte), 0);
    tick(2);
    arst = 1'b1;
    tick(6);
    check("post_rst_idle", int'(busy), 0);

    // drop counter saturation
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      rx_done = 1'b1; rx_byte = 8'(c); dec_err = 1'b1;
    end
    @(negedge clk);
    rx_done = 1'b0; dec_err = 1'b0;
    tick(2);
    check("drop_saturate", int'(drop_cnt), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
